// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and the
// memory-mapped addresses the LSU decodes.
package uart_pkg;

  localparam int          UART_DATA_W  = 8;
  localparam logic [31:0] UART_TX_ADDR = 32'h1000_0000;
  localparam logic [31:0] UART_RX_ADDR = 32'h1000_0004;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO between the LSU store path and the serialiser.
// Read data is presented combinationally from the head entry.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok, pop_ok;

  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_reg[rd_ptr_reg];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: buffers LSU store bytes and sends them
// 8N1, LSB first, with back-to-back frames when the FIFO stays non-empty.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   uart_tx_en,
  input  logic [UART_DATA_W-1:0] uart_tx_data,
  output logic                   uart_tx_ready,
  output logic                   tx,
  output logic                   tx_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BAUD_W       = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ / BAUD must be at least 2");
    end
  endgenerate

  tx_state_t              state_reg, state_next;
  logic [BAUD_W-1:0]      baud_cnt_reg, baud_cnt_next;
  logic [2:0]             bit_idx_reg, bit_idx_next;
  logic [UART_DATA_W-1:0] shift_reg, shift_next;
  logic                   tx_reg, tx_next;

  logic                          fifo_pop;
  logic [UART_DATA_W-1:0]        fifo_rd_data;
  logic                          fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          baud_done;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (uart_tx_en),
    .push_data (uart_tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign baud_done     = (baud_cnt_reg == BAUD_LAST);
  assign uart_tx_ready = !fifo_full;
  assign tx_busy       = (state_reg != IDLE) || (fifo_count != '0);
  assign tx            = tx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
    end
  end

  // tx_next is the line level for the cycle after this edge, so the
  // serial output is a plain flop with no input-to-output path.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_done ? '0 : baud_cnt_reg + 1'b1;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    fifo_pop      = 1'b0;

    case (state_reg)
      IDLE: begin
        baud_cnt_next = '0;
        tx_next       = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_rd_data;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_next   = DATA;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
            tx_next      = shift_reg[1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_rd_data;
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: lane 0 runs at 4 clocks/bit, lane 1 at 3.
// A frame-level reference model predicts frame start cycles and occupancy.
module tb_uart_tx;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      en = '0;
  logic [1:0][7:0] data = '0;
  logic [1:0]      tx_w, rdy_w, busy_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      uart_tx #(
        .CLK_FREQ   (1_000_000),
        .BAUD       ((gi == 0) ? 250_000 : 300_000),
        .FIFO_DEPTH (4)
      ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_tx_en    (en[gi]),
        .uart_tx_data  (data[gi]),
        .uart_tx_ready (rdy_w[gi]),
        .tx            (tx_w[gi]),
        .tx_busy       (busy_w[gi])
      );
    end
  endgenerate

  function automatic int cpb(input int l);
    return (l == 0) ? (1_000_000 / 250_000) : (1_000_000 / 300_000);
  endfunction

  // Reference model: a FIFO of pending bytes plus a countdown of the
  // 10-bit frame currently on the line.
  int         cyc = 0;
  logic [7:0] pend_q [2][$];
  bit         active [2];
  int         remaining [2];
  bit         m_ready [2] = '{1'b1, 1'b1};
  bit         m_busy [2];
  logic [7:0] exp_byte [2][256];
  int         exp_start [2][256];
  int         exp_wr [2];
  int         exp_rd [2];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        pend_q[l].delete();
        active[l]    = 1'b0;
        remaining[l] = 0;
        m_ready[l]   = 1'b1;
        m_busy[l]    = 1'b0;
      end
    end else begin
      cyc++;
      for (int l = 0; l < 2; l++) begin
        bit can_take;
        can_take = (pend_q[l].size() < 4);
        if (active[l]) begin
          remaining[l]--;
          if (remaining[l] == 0) active[l] = 1'b0;
        end
        if (!active[l] && pend_q[l].size() > 0) begin
          exp_byte[l][exp_wr[l] % 256]  = pend_q[l].pop_front();
          exp_start[l][exp_wr[l] % 256] = cyc;
          exp_wr[l]++;
          active[l]    = 1'b1;
          remaining[l] = 10 * cpb(l);
        end
        if (en[l] && can_take) pend_q[l].push_back(data[l]);
        m_ready[l] = (pend_q[l].size() < 4);
        m_busy[l]  = active[l] || (pend_q[l].size() > 0);
      end
    end
  end

  task automatic check(input string name, input int l, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      if (miscompares <= 50)
        $display("FAIL %s lane %0d cycle %0d: got %0d, expected %0d", name, l, cyc, act, req);
    end
  endtask

  // Monitor: compares line level, ready and busy every cycle, and pops one
  // scoreboard entry per frame observed on tx.
  bit         in_frame [2];
  int         fj [2];
  int         bad [2];
  logic [7:0] cur [2];

  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      for (int l = 0; l < 2; l++) begin
        in_frame[l] = 1'b0;
        exp_rd[l]   = exp_wr[l];
        check("reset_tx", l, int'(tx_w[l]), 1);
        check("reset_ready", l, int'(rdy_w[l]), 1);
        check("reset_busy", l, int'(busy_w[l]), 0);
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        check("ready", l, int'(rdy_w[l]), int'(m_ready[l]));
        check("busy", l, int'(busy_w[l]), int'(m_busy[l]));
        if (!in_frame[l]) begin
          if (tx_w[l] == 1'b0) begin
            if (exp_rd[l] != exp_wr[l]) begin
              cur[l] = exp_byte[l][exp_rd[l] % 256];
              check("start_cycle", l, cyc, exp_start[l][exp_rd[l] % 256]);
              exp_rd[l]++;
              in_frame[l] = 1'b1;
              fj[l]  = 0;
              bad[l] = 0;
            end else begin
              check("unexpected_start", l, int'(tx_w[l]), 1);
            end
          end else if (exp_rd[l] != exp_wr[l] && exp_start[l][exp_rd[l] % 256] < cyc) begin
            check("missing_frame", l, int'(tx_w[l]), 0);
            exp_rd[l]++;
          end
        end
        if (in_frame[l]) begin
          int  bi;
          logic expb;
          bi = fj[l] / cpb(l);
          if (bi == 0)      expb = 1'b0;
          else if (bi == 9) expb = 1'b1;
          else              expb = cur[l][bi-1];
          if (tx_w[l] != expb) bad[l]++;
          fj[l]++;
          if (fj[l] == 10 * cpb(l)) begin
            $display("frame lane %0d byte %02h ended cycle %0d, bad bit-cycles %0d",
                     l, cur[l], cyc, bad[l]);
            check("frame_bits", l, bad[l], 0);
            in_frame[l] = 1'b0;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int l, input logic [7:0] b);
    $display("write lane %0d data %02h cycle %0d", l, b, cyc);
    en[l]   = 1'b1;
    data[l] = b;
    @(negedge clk);
    en[l] = 1'b0;
  endtask

  initial begin
    // Inputs toggled under reset must have no effect.
    repeat (8) begin
      @(negedge clk);
      en   = 2'($urandom);
      data = 16'($urandom);
    end
    @(negedge clk);
    en = '0;
    #2 rst_n = 1'b1;
    idle(100);

    wr(0, 8'hA5);
    idle(50);

    // Five accepted back-to-back, sixth dropped on a full FIFO.
    for (int k = 1; k <= 6; k++) wr(0, 8'(k));
    idle(220);

    wr(0, 8'h11);
    idle(37);
    wr(0, 8'h7E);
    idle(50);

    // Reset during data bit 3 with two bytes still queued.
    wr(0, 8'h3C);
    wr(0, 8'h55);
    wr(0, 8'hAA);
    idle(16);
    #2 rst_n = 1'b0;
    idle(3);
    #2 rst_n = 1'b1;
    idle(100);

    wr(1, 8'h80);
    idle(40);

    repeat (400) begin
      en[0]   = ($urandom_range(0, 3) == 0);
      en[1]   = ($urandom_range(0, 5) == 0);
      data[0] = 8'($urandom);
      data[1] = 8'($urandom);
      @(negedge clk);
    end
    en = '0;
    idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
